// File: rtl/booth_pkg.sv
// Shared definitions for the radix-4 Booth sequential multiplier:
// FSM state codes, Booth digit codes and multiplier-extension helpers.
package booth_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CALC  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Booth digit as {zero, neg, two}
    localparam logic [2:0] DIG_ZERO = 3'b100;
    localparam logic [2:0] DIG_PA   = 3'b000;
    localparam logic [2:0] DIG_P2A  = 3'b001;
    localparam logic [2:0] DIG_NA   = 3'b010;
    localparam logic [2:0] DIG_N2A  = 3'b011;

    // Even width plus two keeps a spare sign bit so b_ext is always a valid signed value
    function automatic int booth_wbe(input int wb);
        return (wb % 2 == 0) ? wb + 2 : wb + 1;
    endfunction

    function automatic int booth_iter(input int wb);
        return booth_wbe(wb) / 2;
    endfunction

endpackage

// File: rtl/booth_r4_enc.sv
// Radix-4 Booth window decoder: 3-bit multiplier window to {zero, neg, two}.
module booth_r4_enc
    import booth_pkg::*;
(
    input  logic [2:0] win,
    output logic       zero,
    output logic       neg,
    output logic       two
);

    logic [2:0] dig;

    always_comb begin
        dig = DIG_ZERO;
        case (win)
            3'b001, 3'b010: dig = DIG_PA;
            3'b011:         dig = DIG_P2A;
            3'b100:         dig = DIG_N2A;
            3'b101, 3'b110: dig = DIG_NA;
            default:        dig = DIG_ZERO;
        endcase
    end

    assign zero = dig[2];
    assign neg  = dig[1];
    assign two  = dig[0];

endmodule

// File: rtl/booth_r4_seq.sv
// Sequential radix-4 Booth multiplier, 2 multiplier bits per cycle, PIPE output stages.
// Define BOOTH_UNSIGNED_EN to add a_signed/b_signed operand-signedness inputs.
//
// state    | meaning
// ST_IDLE  | waiting for operands, in_ready=1
// ST_CALC  | ITER Booth iterations, counted down
// ST_DRAIN | product walking through the PIPE output stages
// ST_DONE  | out_valid=1, held until out_ready
module booth_r4_seq
    import booth_pkg::*;
#(
    parameter int WA   = 32,
    parameter int WB   = 32,
    parameter int PIPE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WA-1:0]    a,
    input  logic [WB-1:0]    b,
`ifdef BOOTH_UNSIGNED_EN
    input  logic             a_signed,
    input  logic             b_signed,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WA+WB-1:0] c,
    output logic             busy
);

    localparam int WBE = booth_wbe(WB);
    localparam int ITER = booth_iter(WB);
    localparam int H = WA + 3;
    localparam int WP = WA + WB;
    localparam int CW = 9;
    localparam logic [CW-1:0] ITER_C = CW'(ITER);
    localparam logic [CW-1:0] PIPE_C = CW'(PIPE);

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [WA+1:0] a_ext_r;
    logic [H-1:0]  hi;
    logic [WBE-1:0] lo;
    logic          q;

    logic          a_fill, b_fill;
    logic          zero, neg, two;
    logic [H-1:0]  a_h, a2, mag, pp, sum;
    logic [WP-1:0] prod;

`ifdef BOOTH_UNSIGNED_EN
    assign a_fill = a_signed & a[WA-1];
    assign b_fill = b_signed & b[WB-1];
`else
    assign a_fill = a[WA-1];
    assign b_fill = b[WB-1];
`endif

    booth_r4_enc u_enc (
        .win  ({lo[1:0], q}),
        .zero (zero),
        .neg  (neg),
        .two  (two)
    );

    // One guard bit above the 2a width keeps hi + pp exact
    assign a_h  = {a_ext_r[WA+1], a_ext_r};
    assign a2   = {a_ext_r, 1'b0};
    assign mag  = two ? a2 : a_h;
    assign pp   = zero ? '0 : (neg ? (~mag + H'(1)) : mag);
    assign sum  = hi + pp;
    assign prod = {hi[WP-WBE-1:0], lo};

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            a_ext_r <= '0;
            hi      <= '0;
            lo      <= '0;
            q       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        state   <= ST_CALC;
                        cnt     <= ITER_C;
                        a_ext_r <= {{2{a_fill}}, a};
                        hi      <= '0;
                        lo      <= {{(WBE-WB){b_fill}}, b};
                        q       <= 1'b0;
                    end
                end
                ST_CALC: begin
                    hi <= {{2{sum[H-1]}}, sum[H-1:2]};
                    lo <= {sum[1:0], lo[WBE-1:2]};
                    q  <= lo[1];
                    if (cnt == CW'(1)) begin
                        if (PIPE == 0) begin
                            state <= ST_DONE;
                            cnt   <= '0;
                        end else begin
                            state <= ST_DRAIN;
                            cnt   <= PIPE_C;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                ST_DRAIN: begin
                    if (cnt == CW'(1)) begin
                        state <= ST_DONE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    if (out_ready) state <= ST_IDLE;
                end
            endcase
        end
    end

    // The accumulator is frozen outside CALC, so a free-running chain settles and holds in DONE
    generate
        if (PIPE == 0) begin : g_nopipe
            assign c = prod;
        end else begin : g_pipe
            logic [WP-1:0] stage [PIPE];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < PIPE; i++) stage[i] <= '0;
                end else begin
                    stage[0] <= prod;
                    for (int i = 1; i < PIPE; i++) stage[i] <= stage[i-1];
                end
            end
            assign c = stage[PIPE-1];
        end
    endgenerate

endmodule

// File: doc/booth_r4_seq.md
BOOTH_R4_SEQ -- requirements
Module: booth_r4_seq

Interface
REQ-001 Parameter WA, default 32: multiplicand width in bits; legal range 4..256.
REQ-002 Parameter WB, default 32: multiplier width in bits; legal range 4..256.
REQ-003 Parameter PIPE, default 4: number of output register stages after the iterative core; legal range 0..8.
REQ-004 clk  input  1  clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 in_valid  input  1  operands are valid.
REQ-007 in_ready  output  1  block accepts operands this cycle.
REQ-008 a  input  WA  multiplicand.
REQ-009 b  input  WB  multiplier.
REQ-010 out_valid  output  1  c holds a valid product.
REQ-011 out_ready  input  1  consumer accepts c.
REQ-012 c  output  WA+WB  product.
REQ-013 busy  output  1  a transaction is in flight (state is not IDLE).

Function
REQ-014 The block SHALL compute c = a*b exactly, using a sequential radix-4 Booth algorithm that retires 2 multiplier bits per cycle.
REQ-015 Multiplier extension: b is extended to WBE bits (WB+2 if WB is even, else WB+1); ITER = WBE/2 cycles. Example: WB=32 gives ITER=17.
REQ-016 Multiplicand extension: a is extended to WA+2 bits so that the ±2a partial products never overflow. The accumulator is wide enough to be exact; c is the low WA+WB bits of the accumulator.
REQ-017 FSM states: IDLE, CALC, DRAIN, DONE.
 - IDLE -> CALC on in_valid & in_ready; a and b are captured.
 - CALC runs ITER cycles, counted down by a counter.
 - CALC -> DRAIN after ITER cycles, or -> DONE when PIPE=0.
 - DRAIN -> DONE after PIPE cycles.
 - DONE -> IDLE on out_ready.
REQ-018 in_ready SHALL be 1 only in IDLE; one transaction is in flight at a time.
REQ-019 out_valid SHALL be 1 only in DONE, first asserting exactly ITER+PIPE cycles after the accepting edge.
REQ-020 While out_valid=1 and out_ready=0, c and out_valid SHALL hold stable.
REQ-021 in_valid while not in IDLE is ignored. Captured operands are unaffected by later changes on a or b.
REQ-022 Digit encoding per 3-bit window: 000/111 -> 0; 001/010 -> +a; 011 -> +2a; 100 -> -2a; 101/110 -> -a. Each iteration shifts the accumulator right arithmetically by 2.

Reset
REQ-023 On rst: state=IDLE, counter=0, in_ready=1, out_valid=0, busy=0, c=0, and all pipeline stages are cleared.
REQ-024 rst asserted mid-CALC, mid-DRAIN or in DONE SHALL abort the transaction; no out_valid follows the abort.
REQ-025 rst has priority over simultaneous in_valid and out_ready.

Configuration
REQ-026 Macro BOOTH_UNSIGNED_EN.
 - Defined: adds input ports a_signed (1 bit) and b_signed (1 bit), sampled with the operands. 1 selects sign extension; 0 selects zero extension of that operand.
 - Undefined: these ports are absent, and both operands are always two's complement.

Structure
REQ-027 A shared package booth_pkg SHALL hold the state enum, the Booth digit encoding constants, and a function computing WBE/ITER from WB.
REQ-028 One sub-module, booth_r4_enc: combinational 3-bit window -> {zero, neg, two} decode, instantiated once.
REQ-029 The output pipeline is a plain register chain of length PIPE inside the top module.

Verification
REQ-030 WA=WB=32, PIPE=4, signed: a=0xFFFFFFFF, b=0xFFFFFFFF -> c=0x0000000000000001, with out_valid at accept+21 cycles.
REQ-031 WA=WB=32, signed: a=0x7FFFFFFF, b=0x80000000 -> c=0xC000000080000000.
REQ-032 BOOTH_UNSIGNED_EN defined, a_signed=b_signed=0: a=b=0xFFFFFFFF -> c=0xFFFFFFFE00000001; the same operands with both signed=1 -> c=1.
REQ-033 out_ready held at 0 for 10 cycles in DONE -> c and out_valid stable, in_ready=0; a second in_valid is not accepted until after the handshake.
REQ-034 rst pulsed at CALC cycle 5 -> IDLE and in_ready=1 next cycle, no out_valid; a new transaction a=3, b=-5 -> c=-15.
REQ-035 WA=WB=7, PIPE=0: a=-64, b=-64 -> c=14'h1000, with out_valid at accept+4 cycles.
